// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Shared constants and types for the RV32I core front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    // Datapath width of the core
    localparam int XLEN = 32;

    // ADDI x0, x0, 0: the canonical no-op placed in an empty IF/ID register
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Fetch control states
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

endpackage : rv32i_pkg
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_gen
//  Description : Combinational next-PC select: hold, wrapping increment, or
//                a redirect target clamped to the instruction-memory range.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_gen #(
    parameter int XLEN      = 32,
    parameter int MEM_DEPTH = 7,
    parameter int RESET_PC  = 0
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_advance,
    output logic [XLEN-1:0] o_next_pc
);

    localparam logic [XLEN-1:0] c_depth    = XLEN'(MEM_DEPTH);
    localparam logic [XLEN-1:0] c_last_pc  = XLEN'(MEM_DEPTH - 1);
    localparam logic [XLEN-1:0] c_reset_pc = XLEN'(RESET_PC);

    logic [XLEN-1:0] w_inc_pc;
    logic [XLEN-1:0] w_target_pc;

    // Sequential successor wraps back to word 0 at the top of memory
    always_comb begin
        w_inc_pc = (i_pc == c_last_pc) ? '0 : i_pc + XLEN'(1);
    end

    // Targets outside the memory fall back to the reset vector
    always_comb begin
        w_target_pc = (i_redirect_pc < c_depth) ? i_redirect_pc : c_reset_pc;
    end

    // Redirect outranks sequential advance, otherwise the PC is held
    always_comb begin
        if (i_redirect) begin
            o_next_pc = w_target_pc;
        end else if (i_advance) begin
            o_next_pc = w_inc_pc;
        end else begin
            o_next_pc = i_pc;
        end
    end

endmodule : fetch_pc_gen
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : RV32I instruction fetch. Holds the PC, reads a combinational
//                instruction memory and fills the IF/ID register consumed by
//                decode over valid/ready. Execute redirects flush IF/ID.
//                Optional macro FETCH_PERF_CNT_EN adds transfer/flush counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN      = rv32i_pkg::XLEN,
    parameter int MEM_DEPTH = 7,
    parameter int RESET_PC  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] pc_o,
    input  logic [31:0]     instr_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [31:0]     id_instr_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [XLEN-1:0] id_pc_o,
    output logic [31:0]     fetch_cnt_o,
    output logic [31:0]     flush_cnt_o
`else
    output logic [XLEN-1:0] id_pc_o
`endif
);

    localparam logic [XLEN-1:0] c_reset_pc = XLEN'(RESET_PC);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic            w_capture;
    logic [XLEN-1:0] w_next_pc;

    logic [XLEN-1:0] r_pc;
    logic            r_id_valid;
    logic [31:0]     r_id_instr;
    logic [XLEN-1:0] r_id_pc;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: redirect from any state, otherwise follow the handshake
    always_comb begin
        w_state_nxt = r_state;
        if (redirect_i) begin
            w_state_nxt = FLUSH;
        end else begin
            case (r_state)
                FETCH:   w_state_nxt = (r_id_valid && !id_ready_i) ? STALL : FETCH;
                STALL:   w_state_nxt = id_ready_i ? FETCH : STALL;
                FLUSH:   w_state_nxt = FETCH;
                default: w_state_nxt = FETCH;
            endcase
        end
    end

    // Capture enable: FLUSH always refills the bubble, STALL waits on ready
    always_comb begin
        w_capture = 1'b0;
        case (r_state)
            FETCH:   w_capture = !r_id_valid || id_ready_i;
            STALL:   w_capture = id_ready_i;
            FLUSH:   w_capture = 1'b1;
            default: w_capture = 1'b0;
        endcase
        if (redirect_i) begin
            w_capture = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    fetch_pc_gen #(
        .XLEN      (XLEN),
        .MEM_DEPTH (MEM_DEPTH),
        .RESET_PC  (RESET_PC)
    ) u_pc_gen (
        .i_pc          (r_pc),
        .i_redirect    (redirect_i),
        .i_redirect_pc (redirect_pc_i),
        .i_advance     (w_capture),
        .o_next_pc     (w_next_pc)
    );

    // PC register follows the next-PC mux every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= c_reset_pc;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    // IF/ID register: flush on redirect, load on capture, else hold stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_valid <= 1'b0;
            r_id_instr <= NOP_INSTR;
            r_id_pc    <= '0;
        end else if (redirect_i) begin
            r_id_valid <= 1'b0;
            r_id_instr <= NOP_INSTR;
        end else if (w_capture) begin
            r_id_valid <= 1'b1;
            r_id_instr <= instr_i;
            r_id_pc    <= r_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_flush_cnt;

    // Count decode handshakes and valid entries thrown away by redirects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_id_valid && id_ready_i) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (r_id_valid && redirect_i) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = r_fetch_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

    assign pc_o       = r_pc;
    assign id_valid_o = r_id_valid;
    assign id_instr_o = r_id_instr;
    assign id_pc_o    = r_id_pc;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed self-checking bench for fetch_stage. Counter checks
//                are compiled in when FETCH_PERF_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 7;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic            clk;
    logic            rst_n;
    logic [XLEN-1:0] pc_o;
    logic [31:0]     instr_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            id_valid_o;
    logic            id_ready_i;
    logic [31:0]     id_instr_o;
    logic [XLEN-1:0] id_pc_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]     fetch_cnt_o;
    logic [31:0]     flush_cnt_o;
`endif

    int n_checks;
    int n_fail;

    logic [31:0] mem [DEPTH];

    fetch_stage #(
        .XLEN      (XLEN),
        .MEM_DEPTH (DEPTH),
        .RESET_PC  (0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_o          (pc_o),
        .instr_i       (instr_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_valid_o    (id_valid_o),
        .id_ready_i    (id_ready_i),
        .id_instr_o    (id_instr_o),
`ifdef FETCH_PERF_CNT_EN
        .id_pc_o       (id_pc_o),
        .fetch_cnt_o   (fetch_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
`else
        .id_pc_o       (id_pc_o)
`endif
    );

    // Combinational instruction memory
    always_comb begin
        instr_i = (pc_o < DEPTH) ? mem[pc_o] : 32'hDEAD_BEEF;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_id(input string tag, input logic vld, input int pc_id, input int pc_next);
        chk({tag, ".valid"}, {31'd0, id_valid_o}, {31'd0, vld});
        chk({tag, ".pc"},    pc_o,    pc_next);
        if (vld) begin
            chk({tag, ".id_pc"},    id_pc_o,    pc_id);
            chk({tag, ".id_instr"}, id_instr_o, mem[pc_id]);
        end else begin
            chk({tag, ".id_instr"}, id_instr_o, NOP);
        end
    endtask

    task automatic chk_cnt(input string tag, input int f, input int fl);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, ".fetch_cnt"}, fetch_cnt_o, f);
        chk({tag, ".flush_cnt"}, flush_cnt_o, fl);
`else
        if (f < 0 || fl < 0) $display("bad count arguments in %s", tag);
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + 32'(i * 32'h111);

        rst_n         = 1'b0;
        id_ready_i    = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;

        // Reset state
        step();
        step();
        chk_id("reset", 1'b0, 0, 0);
        chk("reset.id_pc", id_pc_o, 0);
        chk_cnt("reset", 0, 0);

        // Free run: first capture one cycle after release, wraps 6 -> 0
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_id($sformatf("run%0d", i), 1'b1, i % DEPTH, (i + 1) % DEPTH);
        end
        chk_cnt("run", 9, 0);

        // Stall at id_pc 2 for three cycles
        id_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_id($sformatf("stall%0d", i), 1'b1, 2, 3);
        end
        id_ready_i = 1'b1;
        step();
        chk_id("stall_rel", 1'b1, 3, 4);
        chk_cnt("stall_rel", 10, 0);

        // Advance to id_pc 1
        for (int i = 0; i < 5; i++) step();
        chk_id("pre_redir", 1'b1, 1, 2);

        // Redirect to 5: one bubble then 5, 6, 0
        redirect_i    = 1'b1;
        redirect_pc_i = 5;
        step();
        redirect_i = 1'b0;
        chk_id("redir_bubble", 1'b0, 0, 5);
        chk_cnt("redir_bubble", 16, 1);
        step();
        chk_id("redir_t0", 1'b1, 5, 6);
        step();
        chk_id("redir_t1", 1'b1, 6, 0);
        step();
        chk_id("redir_t2", 1'b1, 0, 1);
        chk_cnt("redir_t2", 18, 1);

        // Redirect while stalled: flush wins
        id_ready_i    = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 4;
        step();
        redirect_i = 1'b0;
        chk_id("rstall_bubble", 1'b0, 0, 4);
        step();
        chk_id("rstall_t0", 1'b1, 4, 5);
        step();
        chk_id("rstall_hold", 1'b1, 4, 5);
        id_ready_i = 1'b1;
        step();
        chk_id("rstall_rel", 1'b1, 5, 6);
        chk_cnt("rstall_rel", 19, 2);

        // Out-of-range redirect falls back to reset vector
        redirect_i    = 1'b1;
        redirect_pc_i = 9;
        step();
        redirect_i = 1'b0;
        chk_id("oor_bubble", 1'b0, 0, 0);
        step();
        chk_id("oor_t0", 1'b1, 0, 1);
        chk_cnt("oor_t0", 20, 3);

        // Highest in-range target is honoured
        redirect_i    = 1'b1;
        redirect_pc_i = 6;
        step();
        redirect_i = 1'b0;
        chk_id("edge_bubble", 1'b0, 0, 6);
        step();
        chk_id("edge_t0", 1'b1, 6, 0);
        chk_cnt("edge_t0", 21, 4);

        // Asynchronous reset mid-stall, checked before any clock edge
        id_ready_i = 1'b0;
        step();
        chk_id("astall", 1'b1, 6, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_id("areset", 1'b0, 0, 0);
        chk("areset.id_pc", id_pc_o, 0);
        chk_cnt("areset", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the RV32I core, directly upstream of the instruction memory and directly upstream of decode. Holds the program counter, drives it to the combinational instruction memory, and captures the returned instruction with its PC into an IF/ID pipeline register. Decode consumes that register through a valid/ready handshake. A taken branch or jump from execute redirects fetch and flushes the register.

## Interface
- `XLEN`, 32: datapath and PC width.
- `MEM_DEPTH`, 7: number of instruction-memory words; the PC wraps at this bound.
- `RESET_PC`, 0: PC word index loaded at reset.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pc_o` out XLEN: word index driven to the instruction memory.
- `instr_i` in 32: instruction returned combinationally for `pc_o`.
- `redirect_i` in 1: taken branch/jump from execute.
- `redirect_pc_i` in XLEN: redirect target, word index.
- `id_valid_o` out 1: IF/ID register holds a valid instruction.
- `id_ready_i` in 1: decode accepts the IF/ID contents this cycle.
- `id_instr_o` out 32: registered instruction.
- `id_pc_o` out XLEN: PC of `id_instr_o`.
- `fetch_cnt_o` out 32: instructions handed to decode (only with `FETCH_PERF_CNT_EN`).
- `flush_cnt_o` out 32: valid IF/ID entries discarded by redirect (only with `FETCH_PERF_CNT_EN`).

## Operation
- **Reset values:**
  - `pc_o`=`RESET_PC`, `id_valid_o`=0.
  - `id_instr_o`=32'h00000013 (NOP), `id_pc_o`=0.
  - Counters are 0.
  - FSM is in FETCH.
- **Advance condition:** `adv = !id_valid_o || id_ready_i`.
- **FSM states:**
  - FETCH: IF/ID is empty or being consumed.
  - STALL: IF/ID is valid and `id_ready_i`=0; `pc_o` and IF/ID are held.
  - FLUSH: one bubble cycle after a redirect.
- **FSM transitions:**
  - FETCH→STALL when `id_valid_o` && !`id_ready_i`.
  - STALL→FETCH when `id_ready_i`=1.
  - Any state→FLUSH on `redirect_i`.
  - FLUSH→FETCH unconditionally.
- **Capture:** in FETCH or STALL with `adv`=1 and no redirect:
  - IF/ID ← {`instr_i`, `pc_o`}.
  - `id_valid_o`←1.
  - `pc_o` ← next(`pc_o`).
- **Redirect:** `redirect_i`=1 has priority over capture and stall, including while stalled.
  - `id_valid_o`←0 and `id_instr_o`←NOP.
  - `pc_o` ← `redirect_pc_i` if it is < `MEM_DEPTH`, else `RESET_PC`.
- **FLUSH:** `id_valid_o` stays 0; the capture at the redirect target occurs in this cycle.
- **next(pc):** `pc`+1, and 0 when `pc`==`MEM_DEPTH`-1 (wrap-around).
- **Units:** all PC arithmetic is in words, unsigned, `XLEN` wide; no byte addressing.
- **Reset mid-operation:** asserting `rst_n` low returns every output to its reset value immediately, regardless of state or pending redirect.

## Timing
- `pc_o`, `id_*` and the counters are registered. `instr_i` is used in the same cycle as `pc_o`.
- Latency: `pc_o` in cycle N appears on `id_instr_o`/`id_pc_o` in cycle N+1.
- Throughput is one instruction per cycle while `id_ready_i`=1.
- Handshake: a transfer occurs on a rising edge with `id_valid_o`=1 and `id_ready_i`=1. While stalled, `id_*` stays stable.
- Redirect penalty: exactly one bubble cycle (`id_valid_o`=0).
- The first valid instruction appears one cycle after `rst_n` deasserts.

## Configuration
- **`FETCH_PERF_CNT_EN` defined:**
  - `fetch_cnt_o` increments on every handshake transfer.
  - `flush_cnt_o` increments when a redirect discards a valid IF/ID entry.
  - Both wrap modulo 2^32.
- **Not defined:** both ports and both counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `rv32i_pkg` holds:
  - `NOP_INSTR` (32'h00000013).
  - `XLEN`.
  - The fetch FSM state enum (FETCH, STALL, FLUSH).
- One sub-module, `fetch_pc_gen`: combinational next-PC mux implementing increment, wrap and bounded redirect select.

## Test plan
- **Reset then free-run:** reset, `id_ready_i`=1 → `id_pc_o` sequence 0,1,…,6,0 with instructions matching memory; `id_valid_o` rises one cycle after reset release.
- **Stall:** hold `id_ready_i`=0 for 3 cycles at PC 2 → `pc_o`=3 and `id_pc_o`=2 stay stable; PC 3 is delivered on the cycle after release.
- **Redirect:** redirect to 5 while `id_pc_o`=1 → one bubble, then `id_pc_o`=5, then 6, then 0; `flush_cnt_o`=1.
- **Redirect during stall:** redirect to 4 with `id_ready_i`=0 → flush wins; next valid `id_pc_o`=4.
- **Out-of-range redirect:** redirect to 9 → next valid `id_pc_o`=0.
- **Async reset mid-stall:** drop `rst_n` at an arbitrary phase → `id_valid_o`=0, `pc_o`=0, counters 0 without a clock edge.
